// File: rtl/gpia_bit_in_pkg.sv
// Shared limits and the per-bit read-select rule for the GPIA read-back path.
package gpia_bit_in_pkg;

  localparam int unsigned GPIA_MAX_SYNC_STAGES = 3;

  // A deselected port must contribute zeros so several ports can be ORed onto one bus.
  function automatic logic gpia_read_bit(input logic stb, input logic ddr,
                                         input logic out_bit, input logic pin_bit);
    return stb & (ddr ? out_bit : pin_bit);
  endfunction

endpackage

// File: rtl/gpia_sync.sv
// WIDTH-wide, STAGES-deep pin synchronizer with asynchronous active-low clear.
module gpia_sync
  import gpia_bit_in_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_chain
    logic [STAGES-1:0][WIDTH-1:0] stage_d;
    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/gpia_bit_in.sv
// Per-bit read-back mux: output latch for output bits, synchronized pin for input bits.
module gpia_bit_in
  import gpia_bit_in_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] out_i,
  input  logic [WIDTH-1:0] inp_i,
  input  logic [WIDTH-1:0] ddr_i,
  input  logic             stb_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] inp_s;

  gpia_sync #(
    .WIDTH  (WIDTH),
    .STAGES ((SYNC_STAGES > GPIA_MAX_SYNC_STAGES) ? GPIA_MAX_SYNC_STAGES : SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (inp_i),
    .q_o    (inp_s)
  );

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
    assign q_o[gi] = gpia_read_bit(stb_i, ddr_i[gi], out_i[gi], inp_s[gi]);
  end

endmodule

// File: tb/tb_gpia_bit_in.sv
// Directed bench for gpia_bit_in: vector table plus latency, reset and multi-bit sequences.
module tb_gpia_bit_in;

  logic clk = 1'b0;
  logic rst_n;
  logic stb, ddr, out_b, inp_b;
  logic q1, q_s2, q_s0;
  logic [3:0] out4, inp4, ddr4;
  logic stb4;
  logic [3:0] q4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpia_bit_in #(.WIDTH(1), .SYNC_STAGES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .out_i(out_b), .inp_i(inp_b),
    .ddr_i(ddr), .stb_i(stb), .q_o(q1));

  gpia_bit_in #(.WIDTH(1), .SYNC_STAGES(2)) dut_s2 (
    .clk_i(clk), .rst_ni(rst_n), .out_i(out_b), .inp_i(inp_b),
    .ddr_i(ddr), .stb_i(stb), .q_o(q_s2));

  gpia_bit_in #(.WIDTH(1), .SYNC_STAGES(0)) dut_s0 (
    .clk_i(clk), .rst_ni(rst_n), .out_i(out_b), .inp_i(inp_b),
    .ddr_i(ddr), .stb_i(stb), .q_o(q_s0));

  gpia_bit_in #(.WIDTH(4), .SYNC_STAGES(1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .out_i(out4), .inp_i(inp4),
    .ddr_i(ddr4), .stb_i(stb4), .q_o(q4));

  typedef struct {
    string name;
    logic  stb;
    logic  ddr;
    logic  out_b;
    logic  inp_b;
    logic  exp_q;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: q=%b", name, act);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"stb0_ddr0_00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"stb0_ddr0_10", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"stb0_ddr0_11", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{"stb0_ddr0_01", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"stb0_ddr1_00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"stb0_ddr1_10", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"stb0_ddr1_11", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"stb0_ddr1_01", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"in_00",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"in_10",        1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"in_11",        1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"in_01",        1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{"out_00",       1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"out_10",       1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{"out_11",       1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{"out_01",       1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with an input-mode read of a high pin: synchronizer is clear, so 0.
    rst_n = 1'b0; stb = 1'b1; ddr = 1'b0; out_b = 1'b0; inp_b = 1'b1;
    stb4 = 1'b0; ddr4 = 4'b0000; out4 = 4'b0000; inp4 = 4'b0000;
    after_edge();
    after_edge();
    check("reset_in_mode", {3'b000, q1}, 4'b0000);
    check("reset_in_mode_s2", {3'b000, q_s2}, 4'b0000);
    check("reset_w4", q4, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    inp_b = 1'b0;
    after_edge();

    for (int i = 0; i < 16; i++) begin
      stb = vecs[i].stb; ddr = vecs[i].ddr; out_b = vecs[i].out_b; inp_b = vecs[i].inp_b;
      after_edge();
      check(vecs[i].name, {3'b000, q1}, {3'b000, vecs[i].exp_q});
    end

    // Output-mode read is combinational: visible before any clock edge.
    stb = 1'b1; ddr = 1'b1; out_b = 1'b0; inp_b = 1'b0;
    after_edge();
    out_b = 1'b1;
    #1;
    check("out_same_cycle", {3'b000, q1}, 4'b0001);
    ddr = 1'b0;
    #1;
    check("ddr_switch_same_cycle", {3'b000, q1}, 4'b0000);

    // Latency sweep across 0, 1 and 2 synchronizer stages.
    after_edge();
    after_edge();
    inp_b = 1'b1;
    #1;
    check("lat_s1_before_edge", {3'b000, q1}, 4'b0000);
    check("lat_s2_before_edge", {3'b000, q_s2}, 4'b0000);
    check("lat_s0_immediate", {3'b000, q_s0}, 4'b0001);
    after_edge();
    check("lat_s1_edge1", {3'b000, q1}, 4'b0001);
    check("lat_s2_edge1", {3'b000, q_s2}, 4'b0000);
    after_edge();
    check("lat_s2_edge2", {3'b000, q_s2}, 4'b0001);

    // Asynchronous reset mid-cycle clears input-mode reads without a clock.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_in", {3'b000, q1}, 4'b0000);
    check("async_reset_in_s2", {3'b000, q_s2}, 4'b0000);
    ddr = 1'b1; out_b = 1'b1;
    #1;
    check("reset_out_mode", {3'b000, q1}, 4'b0001);
    stb = 1'b0;
    #1;
    check("reset_out_mode_stb0", {3'b000, q1}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    stb = 1'b1; ddr = 1'b0;
    after_edge();
    check("resample_after_reset", {3'b000, q1}, 4'b0001);

    // Mixed directions on a 4-bit port.
    ddr4 = 4'b1100; out4 = 4'b1010; inp4 = 4'b0110; stb4 = 1'b1;
    after_edge();
    check("w4_mixed", q4, 4'b1010);
    stb4 = 1'b0;
    #1;
    check("w4_stb0", q4, 4'b0000);
    ddr4 = 4'b0011; stb4 = 1'b1;
    #1;
    check("w4_mixed_swapped", q4, 4'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
